// File: rtl/ysyx_22041207_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ysyx_22041207_mem_arbiter
// Purpose : Merges the IF fetch port and the MEM data port onto the single
//           one-outstanding request/response port of the axi_rw bridge.
// Rev     : 1.0  initial release
// ============================================================================
module ysyx_22041207_mem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        if_valid,
   output logic        if_ready,
   input  logic [63:0] if_addr,
   output logic        if_rvalid,
   output logic [63:0] if_rdata,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic        mem_write,
   input  logic [63:0] mem_addr,
   input  logic [7:0]  mem_size,
   input  logic [63:0] mem_wdata,
   input  logic [7:0]  mem_wstrb,
   output logic        mem_rvalid,
   output logic [63:0] mem_rdata,
   output logic        dn_valid,
   input  logic        dn_ready,
   output logic        dn_write,
   output logic [63:0] dn_addr,
   output logic [7:0]  dn_size,
   output logic [63:0] dn_wdata,
   output logic [7:0]  dn_wstrb,
   input  logic        dn_rvalid,
   input  logic [63:0] dn_rdata
);

   localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  starve_q, starve_d;
   logic        owner_q, owner_d;     // 1 = IF owns the transaction
   logic        drop_q, drop_d;
   logic        dn_write_q, dn_write_d;
   logic [63:0] dn_addr_q, dn_addr_d;
   logic [7:0]  dn_size_q, dn_size_d;
   logic [63:0] dn_wdata_q, dn_wdata_d;
   logic [7:0]  dn_wstrb_q, dn_wstrb_d;
   logic [63:0] if_rdata_q, if_rdata_d;
   logic [63:0] mem_rdata_q, mem_rdata_d;

   logic w_idle, w_if_win, w_mem_win;

   // A flushing cycle keeps IF out of arbitration, so MEM may take the slot.
   assign w_idle    = (state_q == S_IDLE);
   assign w_if_win  = w_idle & if_valid & ~flush & (~mem_valid | (starve_q == C_LIMIT));
   assign w_mem_win = w_idle & mem_valid & ~w_if_win;

   assign if_ready   = rst & w_if_win;
   assign mem_ready  = rst & w_mem_win;
   assign dn_valid   = (state_q == S_ISSUE);
   assign if_rvalid  = (state_q == S_RESP) & owner_q & ~drop_q & ~flush;
   assign mem_rvalid = (state_q == S_RESP) & ~owner_q;
   assign dn_write   = dn_write_q;
   assign dn_addr    = dn_addr_q;
   assign dn_size    = dn_size_q;
   assign dn_wdata   = dn_wdata_q;
   assign dn_wstrb   = dn_wstrb_q;
   assign if_rdata   = if_rdata_q;
   assign mem_rdata  = mem_rdata_q;

   always_comb begin
      state_d     = state_q;
      starve_d    = starve_q;
      owner_d     = owner_q;
      drop_d      = drop_q;
      dn_write_d  = dn_write_q;
      dn_addr_d   = dn_addr_q;
      dn_size_d   = dn_size_q;
      dn_wdata_d  = dn_wdata_q;
      dn_wstrb_d  = dn_wstrb_q;
      if_rdata_d  = if_rdata_q;
      mem_rdata_d = mem_rdata_q;

      case (state_q)
         S_IDLE: begin
            drop_d = 1'b0;
            if (!if_valid || w_if_win) begin
               starve_d = 4'd0;
            end else if (w_mem_win && (starve_q < C_LIMIT)) begin
               starve_d = starve_q + 4'd1;
            end
            if (w_if_win) begin
               owner_d    = 1'b1;
               dn_write_d = 1'b0;
               dn_addr_d  = if_addr;
               dn_size_d  = 8'd8;
               dn_wdata_d = 64'd0;
               dn_wstrb_d = 8'd0;
               state_d    = S_ISSUE;
            end else if (w_mem_win) begin
               owner_d    = 1'b0;
               dn_write_d = mem_write;
               dn_addr_d  = mem_addr;
               dn_size_d  = mem_size;
               dn_wdata_d = mem_wdata;
               dn_wstrb_d = mem_wstrb;
               state_d    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (flush && owner_q) drop_d = 1'b1;
            if (dn_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (flush && owner_q) drop_d = 1'b1;
            if (dn_rvalid) begin
               if (owner_q) if_rdata_d  = dn_rdata;
               else         mem_rdata_d = dn_rdata;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            // A flush here is already honoured combinationally on if_rvalid.
            drop_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         starve_q    <= 4'd0;
         owner_q     <= 1'b0;
         drop_q      <= 1'b0;
         dn_write_q  <= 1'b0;
         dn_addr_q   <= 64'd0;
         dn_size_q   <= 8'd0;
         dn_wdata_q  <= 64'd0;
         dn_wstrb_q  <= 8'd0;
         if_rdata_q  <= 64'd0;
         mem_rdata_q <= 64'd0;
      end else begin
         state_q     <= state_d;
         starve_q    <= starve_d;
         owner_q     <= owner_d;
         drop_q      <= drop_d;
         dn_write_q  <= dn_write_d;
         dn_addr_q   <= dn_addr_d;
         dn_size_q   <= dn_size_d;
         dn_wdata_q  <= dn_wdata_d;
         dn_wstrb_q  <= dn_wstrb_d;
         if_rdata_q  <= if_rdata_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041207_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_ysyx_22041207_mem_arbiter
// Purpose : Transaction-level model checking of the IF/MEM arbiter.
// Rev     : 1.0  initial release
// ============================================================================
module tb_ysyx_22041207_mem_arbiter;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        flush = 1'b0;
   logic        if_valid = 1'b0, if_ready, if_rvalid;
   logic [63:0] if_addr = 64'd0, if_rdata;
   logic        mem_valid = 1'b0, mem_ready, mem_write = 1'b0, mem_rvalid;
   logic [63:0] mem_addr = 64'd0, mem_wdata = 64'd0, mem_rdata;
   logic [7:0]  mem_size = 8'd0, mem_wstrb = 8'd0;
   logic        dn_valid, dn_ready = 1'b0, dn_write, dn_rvalid = 1'b0;
   logic [63:0] dn_addr, dn_wdata, dn_rdata = 64'd0;
   logic [7:0]  dn_size, dn_wstrb;

   ysyx_22041207_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
      .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_size(mem_size), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_write(dn_write),
      .dn_addr(dn_addr), .dn_size(dn_size), .dn_wdata(dn_wdata),
      .dn_wstrb(dn_wstrb), .dn_rvalid(dn_rvalid), .dn_rdata(dn_rdata)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Transaction-level model: one record for the single outstanding request.
   bit          m_busy, m_issued, m_resp, m_own_if, m_drop;
   int          m_starve;
   logic [63:0] m_resp_data;
   logic        m_dn_write;
   logic [63:0] m_dn_addr, m_dn_wdata;
   logic [7:0]  m_dn_size, m_dn_wstrb;

   // Bench-side bridge
   bit br_auto, br_rand;
   int br_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit if_wins();
      return !m_busy && if_valid && !flush && (!mem_valid || m_starve == LIMIT);
   endfunction

   function automatic bit mem_wins();
      return !m_busy && mem_valid && !if_wins();
   endfunction

   task automatic compare();
      bit exp_ifr, exp_memr;
      exp_ifr  = m_resp && m_own_if && !m_drop && !flush;
      exp_memr = m_resp && !m_own_if;
      chk("if_ready",   if_ready,   rst && if_wins());
      chk("mem_ready",  mem_ready,  rst && mem_wins());
      chk("dn_valid",   dn_valid,   m_busy && !m_issued);
      chk("if_rvalid",  if_rvalid,  exp_ifr);
      chk("mem_rvalid", mem_rvalid, exp_memr);
      if (exp_ifr)  chk("if_rdata",  if_rdata,  m_resp_data);
      if (exp_memr) chk("mem_rdata", mem_rdata, m_resp_data);
      chk("dn_write", dn_write, m_dn_write);
      chk("dn_addr",  dn_addr,  m_dn_addr);
      chk("dn_size",  dn_size,  m_dn_size);
      chk("dn_wdata", dn_wdata, m_dn_wdata);
      chk("dn_wstrb", dn_wstrb, m_dn_wstrb);
   endtask

   task automatic model_step();
      bit iw, mw;
      iw = if_wins();
      mw = mem_wins();
      if (!rst) begin
         m_busy = 0; m_issued = 0; m_resp = 0; m_own_if = 0; m_drop = 0;
         m_starve = 0; m_dn_write = 0; m_dn_addr = 0; m_dn_size = 0;
         m_dn_wdata = 0; m_dn_wstrb = 0;
      end else if (m_resp) begin
         m_busy = 0; m_resp = 0; m_drop = 0;
      end else if (m_busy) begin
         if (flush && m_own_if) m_drop = 1;
         if (!m_issued) begin
            if (dn_ready) m_issued = 1;
         end else if (dn_rvalid) begin
            m_resp = 1;
            m_resp_data = dn_rdata;
         end
      end else begin
         if (!if_valid || iw) m_starve = 0;
         else if (mw && m_starve < LIMIT) m_starve++;
         if (iw) begin
            m_busy = 1; m_issued = 0; m_own_if = 1;
            m_dn_write = 0; m_dn_addr = if_addr; m_dn_size = 8;
            m_dn_wdata = 0; m_dn_wstrb = 0;
         end else if (mw) begin
            m_busy = 1; m_issued = 0; m_own_if = 0;
            m_dn_write = mem_write; m_dn_addr = mem_addr; m_dn_size = mem_size;
            m_dn_wdata = mem_wdata; m_dn_wstrb = mem_wstrb;
         end
      end
   endtask

   task automatic settle();
      if (br_auto) begin
         dn_rvalid = (br_cnt == 1);
         dn_rdata  = {$urandom, $urandom};
         if (br_cnt > 0) br_cnt--;
      end
      #3;
      compare();
   endtask

   task automatic tick();
      bit accepted;
      accepted = rst && dn_valid && dn_ready;
      model_step();
      if (!rst) br_cnt = 0;
      else if (br_auto && accepted) br_cnt = br_rand ? $urandom_range(1, 3) : 1;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      flush = 0; if_valid = 0; mem_valid = 0; mem_write = 0;
      dn_ready = 0; dn_rvalid = 0;
   endtask

   initial begin
      logic [9:0] grants;
      int         ng;
      br_auto = 0; br_rand = 0; br_cnt = 0;
      @(posedge clk); #1;

      // Reset and post-reset state
      rst = 0; idle_inputs();
      settle(); tick();
      settle(); tick();
      rst = 1;
      settle();
      chk("rst dn_valid",  dn_valid,  0);
      chk("rst dn_addr",   dn_addr,   0);
      chk("rst if_rvalid", if_rvalid, 0);
      chk("rst mem_rdata", mem_rdata, 0);
      tick();

      // Single IF read, N = 1
      if_valid = 1; if_addr = 64'h8000_0000; dn_ready = 1;
      settle(); chk("ifrd ready", if_ready, 1); tick();
      if_valid = 0;
      settle();
      chk("ifrd dn_valid", dn_valid, 1);
      chk("ifrd dn_addr",  dn_addr,  64'h8000_0000);
      chk("ifrd dn_write", dn_write, 0);
      tick();
      dn_ready = 0; dn_rvalid = 1; dn_rdata = 64'h0000_0013_0010_0093;
      settle(); tick();
      dn_rvalid = 0;
      settle();
      chk("ifrd rvalid", if_rvalid, 1);
      chk("ifrd rdata",  if_rdata,  64'h0000_0013_0010_0093);
      tick();

      // MEM write with bridge back-pressure
      mem_valid = 1; mem_write = 1; mem_addr = 64'h8000_1000; mem_wdata = 64'hDEAD_BEEF;
      mem_wstrb = 8'h0F; mem_size = 8'd4;
      settle(); chk("mw ready", mem_ready, 1); tick();
      mem_valid = 0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("mw hold valid", dn_valid, 1);
         chk("mw hold wdata", dn_wdata, 64'hDEAD_BEEF);
         chk("mw hold wstrb", dn_wstrb, 8'h0F);
         tick();
      end
      dn_ready = 1; settle(); tick();
      dn_ready = 0; dn_rvalid = 1; dn_rdata = 64'h0; settle(); tick();
      dn_rvalid = 0;
      settle();
      chk("mw rvalid", mem_rvalid, 1);
      chk("mw no if_rvalid", if_rvalid, 0);
      tick();
      settle(); chk("mw single pulse", mem_rvalid, 0); tick();

      // Contention: both always valid, bridge answers after one cycle
      br_auto = 1; br_rand = 0; br_cnt = 0;
      if_valid = 1; mem_valid = 1; mem_write = 0; dn_ready = 1;
      grants = '0; ng = 0;
      for (int c = 0; c < 80 && ng < 10; c++) begin
         settle();
         if (if_ready || mem_ready) begin
            grants[9 - ng] = if_ready;
            ng++;
         end
         tick();
      end
      chk("contention grant count", ng, 10);
      chk("contention order", grants, 10'b0000100001);
      idle_inputs();
      for (int c = 0; c < 4; c++) begin settle(); tick(); end
      br_auto = 0;

      // Flush during IF WAIT
      if_valid = 1; if_addr = 64'h8000_0040; dn_ready = 1;
      settle(); tick();
      if_valid = 0; settle(); tick();
      dn_ready = 0; flush = 1; settle(); tick();
      flush = 0; dn_rvalid = 1; dn_rdata = 64'h1234; settle(); tick();
      dn_rvalid = 0;
      settle(); chk("flush no if_rvalid", if_rvalid, 0); tick();
      mem_valid = 1; mem_write = 0; mem_addr = 64'h8000_2000; mem_size = 8'd8;
      settle(); chk("flush then mem_ready", mem_ready, 1); tick();
      mem_valid = 0; dn_ready = 1; settle(); tick();

      // Reset while in WAIT; late response ignored
      dn_ready = 0; rst = 0; settle(); tick();
      rst = 1;
      settle();
      chk("midrst dn_valid", dn_valid, 0);
      chk("midrst dn_addr",  dn_addr,  0);
      chk("midrst mem_rdata", mem_rdata, 0);
      tick();
      dn_rvalid = 1; dn_rdata = 64'hBAD; settle(); tick();
      dn_rvalid = 0;
      settle(); chk("midrst no mem_rvalid", mem_rvalid, 0); tick();

      // Flush while MEM owns the bridge
      mem_valid = 1; mem_write = 0; mem_addr = 64'h8000_3000; mem_size = 8'd2;
      settle(); tick();
      mem_valid = 0; dn_ready = 1; settle(); tick();
      dn_ready = 0; flush = 1; dn_rvalid = 1; dn_rdata = 64'hCAFE_F00D_0000_5555;
      settle(); tick();
      flush = 0; dn_rvalid = 0;
      settle();
      chk("memflush rvalid", mem_rvalid, 1);
      chk("memflush rdata",  mem_rdata, 64'hCAFE_F00D_0000_5555);
      tick();

      // Randomised traffic
      br_auto = 1; br_rand = 1; br_cnt = 0;
      for (int n = 0; n < 3000; n++) begin
         rst       = ($urandom_range(0, 299) != 0);
         flush     = ($urandom_range(0, 7) == 0);
         if_valid  = ($urandom_range(0, 2) != 0);
         mem_valid = 1'($urandom_range(0, 1));
         mem_write = 1'($urandom_range(0, 1));
         if_addr   = {$urandom, $urandom};
         mem_addr  = {$urandom, $urandom};
         mem_wdata = {$urandom, $urandom};
         mem_wstrb = 8'($urandom);
         mem_size  = 8'(1 << $urandom_range(0, 3));
         dn_ready  = 1'($urandom_range(0, 1));
         settle();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
